move_list_streamer: RTL
=======================

// Module: move_list_streamer
// PURPOSE
//  Synthesisable successor to the bench-side move display loop: after all_moves asserts am_moves_ready, walks
//  move indices 0..am_move_count-1, waits a parametrised move-RAM read latency, and streams each move over a
//  valid/ready interface. Adds a capture-only filter, a terminal status word (mate/stalemate/empty) and a
//  handshaken am_clear_moves release. Sits between all_moves and the search/debug consumer.
// PARAMETERS
//  MAX_POSITIONS_LOG2  7   width of move index/count
//  EVAL_WIDTH          24  width of eval field
//  UCI_WIDTH           16  promotion[15:12], to[11:6], from[5:0]
//  READ_LATENCY        2   cycles from am_move_index change to valid uci/capture/check/eval inputs (1..7)
// PORTS
//  clk                  in   1    clock
//  reset                in   1    synchronous, active-high reset
//  capture_only         in   1    1: emit only moves with capture_in=1; sampled at list start
//  am_moves_ready       in   1    all_moves list complete
//  am_move_count        in   MAX_POSITIONS_LOG2  number of legal moves
//  initial_mate         in   1    position is checkmate
//  initial_stalemate    in   1    position is stalemate
//  uci_in               in   UCI_WIDTH  uci_out of all_moves for current index
//  capture_in           in   1    capture_out for current index
//  white_in_check_in    in   1    white_in_check_out for current index
//  black_in_check_in    in   1    black_in_check_out for current index
//  eval_in              in   EVAL_WIDTH  eval_out for current index (signed)
//  am_move_index        out  MAX_POSITIONS_LOG2  read index to all_moves
//  am_clear_moves       out  1    one-cycle pulse releasing all_moves
//  mv_valid             out  1    move beat valid
//  mv_ready             in   1    consumer accepts beat
//  mv_uci / mv_index    out  UCI_WIDTH / MAX_POSITIONS_LOG2  move and its list index
//  mv_capture, mv_check out  1 each  capture; side-to-move-after gives check (white|black in check)
//  mv_eval              out  EVAL_WIDTH  eval
//  mv_last              out  1    final beat of list
//  done_valid           out  1    one-cycle pulse: list finished
//  done_status          out  2    0 moves emitted, 1 mate, 2 stalemate, 3 zero moves emitted (filtered/none)
//  emitted_count        out  MAX_POSITIONS_LOG2  beats accepted in this list (held until next start)
// BEHAVIOUR
//  Reset: state IDLE; am_move_index=0, am_clear_moves=0, mv_valid=0, mv_last=0, done_valid=0, done_status=0,
//   emitted_count=0, all mv_* data 0. Reset mid-list abandons it with no clear pulse and no done.
//  States: IDLE -> START -> (READ -> WAIT -> EVAL -> PRESENT)* -> FINISH -> CLEAR -> CLEAR_WAIT -> IDLE.
//  IDLE: on am_moves_ready=1 latch count and capture_only, emitted_count<=0, index<=0 -> START.
//  START: count==0 -> FINISH with status mate(1) if initial_mate, else stalemate(2) if initial_stalemate,
//   else 3; count>0 -> READ.
//  READ: drive am_move_index; load wait counter with READ_LATENCY-1 -> WAIT; WAIT decrements to 0 -> EVAL.
//   Index held constant from READ through PRESENT; total READ->EVAL = READ_LATENCY cycles.
//  EVAL: skip if capture_only and !capture_in. Otherwise register mv_* from inputs, mv_valid<=1 -> PRESENT.
//   Look-ahead for mv_last is not possible under filter: mv_last=1 only when index==count-1; with filter
//   the final kept move may carry mv_last=0 (done_valid marks completion).
//   On skip: index==count-1 -> FINISH else index+1 -> READ.
//  PRESENT: mv_* stable while mv_valid && !mv_ready. On mv_valid&&mv_ready: mv_valid<=0,
//   emitted_count+1, then index==count-1 -> FINISH else index+1 -> READ. Max one beat per READ_LATENCY+2 cycles.
//  FINISH: done_valid=1 one cycle; done_status 0 if emitted_count>0, else 3 (or 1/2 from START path) -> CLEAR.
//  CLEAR: am_clear_moves=1 one cycle, am_move_index<=0 -> CLEAR_WAIT (one cycle, ignores am_moves_ready,
//   lets all_moves drop ready) -> IDLE.
//  am_moves_ready outside IDLE ignored. Index increments never wrap: terminal compare on count-1.
//  mv_check = white_in_check_in | black_in_check_in; eval passed through unmodified (signed).
// TESTING
//  20-move start position, mv_ready=1, READ_LATENCY=2 -> 20 beats, indices 0..19, mv_last on 19 only,
//   done_status=0, emitted_count=20, single am_clear_moves pulse, then IDLE.
//  Same list, mv_ready toggled 1-in-3 -> beats identical, data stable while stalled, no loss or duplicate.
//  capture_only=1 on position with 3 captures among 30 moves -> exactly 3 beats, emitted_count=3, status 0;
//   position with 0 captures -> 0 beats, status 3.
//  am_move_count=0 with initial_mate=1 -> no beats, done_status=1, clear pulse; initial_stalemate=1 -> status 2.
//  READ_LATENCY=1 and 7 sweep -> index-to-sample spacing exactly latency; data matches model per index.
//  reset asserted during PRESENT of beat 5 -> next cycle mv_valid=0, am_clear_moves=0, no done_valid; fresh
//   am_moves_ready restarts at index 0.

Source files
------------

// File: rtl/move_list_streamer.sv
// Walks the all_moves list after am_moves_ready, waits out the move-RAM read latency per index and
// streams each (optionally capture-filtered) move over valid/ready, then reports status and releases all_moves.
module move_list_streamer #(
  parameter int MAX_POSITIONS_LOG2 = 7,
  parameter int EVAL_WIDTH         = 24,
  parameter int UCI_WIDTH          = 16,
  parameter int READ_LATENCY       = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                capture_only,
  input  logic                                am_moves_ready,
  input  logic [MAX_POSITIONS_LOG2-1:0]       am_move_count,
  input  logic                                initial_mate,
  input  logic                                initial_stalemate,
  input  logic [UCI_WIDTH-1:0]                uci_in,
  input  logic                                capture_in,
  input  logic                                white_in_check_in,
  input  logic                                black_in_check_in,
  input  logic signed [EVAL_WIDTH-1:0]        eval_in,
  output logic [MAX_POSITIONS_LOG2-1:0]       am_move_index,
  output logic                                am_clear_moves,
  output logic                                mv_valid,
  input  logic                                mv_ready,
  output logic [UCI_WIDTH-1:0]                mv_uci,
  output logic [MAX_POSITIONS_LOG2-1:0]       mv_index,
  output logic                                mv_capture,
  output logic                                mv_check,
  output logic signed [EVAL_WIDTH-1:0]        mv_eval,
  output logic                                mv_last,
  output logic                                done_valid,
  output logic [1:0]                          done_status,
  output logic [MAX_POSITIONS_LOG2-1:0]       emitted_count
);
  localparam int PW = MAX_POSITIONS_LOG2;
  localparam logic [2:0] WAIT_INIT = 3'(READ_LATENCY - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_READ, S_WAIT, S_EVAL, S_PRESENT, S_FINISH, S_CLEAR, S_CLEAR_WAIT
  } state_t;

  state_t                 state_q;
  logic [PW-1:0]          count_q, idx_q, emit_q;
  logic                   co_q;
  logic [2:0]             wait_q;
  logic                   valid_q, last_q, cap_q, chk_q, done_q, clear_q;
  logic [UCI_WIDTH-1:0]   uci_q;
  logic [PW-1:0]          mv_idx_q;
  logic signed [EVAL_WIDTH-1:0] eval_q;
  logic [1:0]             status_q;

  logic          at_last;
  logic [PW-1:0] idx_d;
  // Terminal test is on count-1 so the index never has to wrap past the list end.
  assign at_last = (idx_q == (count_q - PW'(1)));
  assign idx_d   = idx_q + PW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      idx_q    <= '0;
      emit_q   <= '0;
      co_q     <= 1'b0;
      wait_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      cap_q    <= 1'b0;
      chk_q    <= 1'b0;
      uci_q    <= '0;
      mv_idx_q <= '0;
      eval_q   <= '0;
      done_q   <= 1'b0;
      clear_q  <= 1'b0;
      status_q <= 2'd0;
    end else begin
      done_q  <= 1'b0;
      clear_q <= 1'b0;
      case (state_q)
        S_IDLE: if (am_moves_ready) begin
          count_q <= am_move_count;
          co_q    <= capture_only;
          emit_q  <= '0;
          idx_q   <= '0;
          state_q <= S_START;
        end
        S_START: begin
          if (count_q == '0) begin
            status_q <= initial_mate ? 2'd1 : (initial_stalemate ? 2'd2 : 2'd3);
            state_q  <= S_FINISH;
          end else begin
            state_q <= S_READ;
          end
        end
        // The READ cycle itself counts toward the latency, so latency 1 skips WAIT.
        S_READ: begin
          wait_q  <= WAIT_INIT;
          state_q <= (READ_LATENCY == 1) ? S_EVAL : S_WAIT;
        end
        S_WAIT: begin
          wait_q <= wait_q - 3'd1;
          if (wait_q <= 3'd1) state_q <= S_EVAL;
        end
        S_EVAL: begin
          if (co_q && !capture_in) begin
            if (at_last) state_q <= S_FINISH;
            else begin
              idx_q   <= idx_d;
              state_q <= S_READ;
            end
          end else begin
            uci_q    <= uci_in;
            mv_idx_q <= idx_q;
            cap_q    <= capture_in;
            chk_q    <= white_in_check_in | black_in_check_in;
            eval_q   <= eval_in;
            last_q   <= at_last;
            valid_q  <= 1'b1;
            state_q  <= S_PRESENT;
          end
        end
        S_PRESENT: if (mv_ready) begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          emit_q  <= emit_q + PW'(1);
          if (at_last) state_q <= S_FINISH;
          else begin
            idx_q   <= idx_d;
            state_q <= S_READ;
          end
        end
        S_FINISH: begin
          done_q <= 1'b1;
          if (count_q != '0) status_q <= (emit_q != '0) ? 2'd0 : 2'd3;
          state_q <= S_CLEAR;
        end
        S_CLEAR: begin
          clear_q <= 1'b1;
          idx_q   <= '0;
          state_q <= S_CLEAR_WAIT;
        end
        S_CLEAR_WAIT: state_q <= S_IDLE;
        default:      state_q <= S_IDLE;
      endcase
    end
  end

  assign am_move_index  = idx_q;
  assign am_clear_moves = clear_q;
  assign mv_valid       = valid_q;
  assign mv_uci         = uci_q;
  assign mv_index       = mv_idx_q;
  assign mv_capture     = cap_q;
  assign mv_check       = chk_q;
  assign mv_eval        = eval_q;
  assign mv_last        = last_q;
  assign done_valid     = done_q;
  assign done_status    = status_q;
  assign emitted_count  = emit_q;
endmodule
